// File: rtl/alu_seq_n_if.sv
// Issue/writeback handshake bundle for alu_seq_n.
// The issue stage drives the master side and the ALU implements the slave side.
interface alu_seq_n_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [5:0]       status;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, status, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, status, err
  );
endinterface

// File: rtl/alu_seq_n.sv
// Handshaked sequential ALU with a persistent {PF,AF,OF,SF,ZF,CF} status register.
// Shifts and rotates advance one bit per cycle; all other ops complete in one cycle.
module alu_seq_n #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic             work_cf_q;
  logic [CW-1:0]    cnt_q;
  logic             single_q;
  logic             a_msb_q;
  logic [WIDTH-1:0] result_q;
  logic [5:0]       status_q;
  logic             err_q;

  logic             accept;
  logic             go_exec;
  logic             last_step;
  logic [CW-1:0]    cnt_in;

  logic [WIDTH-1:0] opnd;
  logic             cin;
  logic             sub;
  logic [WIDTH:0]   sum;
  logic             arith_of;
  logic             arith_af;

  logic [WIDTH-1:0] imm_result;
  logic [5:0]       imm_status;
  logic             imm_err;

  logic [WIDTH-1:0] step_val;
  logic             step_cf;
  logic             one_of;
  logic [5:0]       fin_status;

  function automatic logic [5:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic cf,
                                            input logic of,
                                            input logic af);
    return {~^r[7:0], af, of, r[WIDTH-1], (r == '0), cf};
  endfunction

  assign cnt_in    = bus.b[CW-1:0];
  assign accept    = bus.in_valid && (state == IDLE);
  assign go_exec   = (bus.op[4:3] == 2'b10) && (cnt_in != '0);
  assign last_step = (state == EXEC) && (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = go_exec ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (cnt_q == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.result = result_q;
  assign bus.status = status_q;
  assign bus.err    = err_q;

  // Add/subtract share one adder; INC/DEC use a constant one as operand B.
  always_comb begin
    opnd = '0;
    cin  = 1'b0;
    sub  = 1'b0;
    case (bus.op)
      OP_INC: opnd = ONE;
      OP_DEC: begin
        opnd = ONE;
        sub  = 1'b1;
      end
      OP_ADD: opnd = bus.b;
      OP_ADC: begin
        opnd = bus.b;
        cin  = status_q[0];
      end
      OP_SUB: begin
        opnd = bus.b;
        sub  = 1'b1;
      end
      OP_SBB: begin
        opnd = bus.b;
        cin  = status_q[0];
        sub  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = sub ? ({1'b0, bus.a} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin})
                   : ({1'b0, bus.a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin});

  assign arith_of = (sub ? (bus.a[WIDTH-1] != opnd[WIDTH-1])
                         : (bus.a[WIDTH-1] == opnd[WIDTH-1]))
                    && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign arith_af = bus.a[4] ^ opnd[4] ^ sum[4];

  always_comb begin
    imm_result = '0;
    imm_status = status_q;
    imm_err    = 1'b0;
    case (bus.op)
      OP_INC, OP_DEC: begin
        imm_result = sum[WIDTH-1:0];
        imm_status = pack_flags(sum[WIDTH-1:0], status_q[0], arith_of, arith_af);
      end
      OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
        imm_result = sum[WIDTH-1:0];
        imm_status = pack_flags(sum[WIDTH-1:0], sum[WIDTH], arith_of, arith_af);
      end
      OP_AND: begin
        imm_result = bus.a & bus.b;
        imm_status = pack_flags(bus.a & bus.b, 1'b0, 1'b0, 1'b0);
      end
      OP_OR: begin
        imm_result = bus.a | bus.b;
        imm_status = pack_flags(bus.a | bus.b, 1'b0, 1'b0, 1'b0);
      end
      OP_XOR: begin
        imm_result = bus.a ^ bus.b;
        imm_status = pack_flags(bus.a ^ bus.b, 1'b0, 1'b0, 1'b0);
      end
      OP_NOT: begin
        imm_result = ~bus.a;
        imm_status = pack_flags(~bus.a, 1'b0, 1'b0, 1'b0);
      end
      OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
        imm_result = bus.a;
      end
      default: imm_err = 1'b1;
    endcase
  end

  // One bit of shift/rotate; RCL/RCR treat {work_cf_q, work_q} as a WIDTH+1 ring.
  always_comb begin
    step_val = work_q;
    step_cf  = work_cf_q;
    case (op_q)
      OP_SHL, OP_SAL: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        step_cf  = work_q[WIDTH-1];
      end
      OP_SHR: begin
        step_val = {1'b0, work_q[WIDTH-1:1]};
        step_cf  = work_q[0];
      end
      OP_SAR: begin
        step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_cf  = work_q[0];
      end
      OP_ROL: begin
        step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        step_cf  = work_q[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {work_q[0], work_q[WIDTH-1:1]};
        step_cf  = work_q[0];
      end
      OP_RCL: begin
        step_val = {work_q[WIDTH-2:0], work_cf_q};
        step_cf  = work_q[WIDTH-1];
      end
      OP_RCR: begin
        step_val = {work_cf_q, work_q[WIDTH-1:1]};
        step_cf  = work_q[0];
      end
      default: ;
    endcase
  end

  // OF is only defined for a single-bit shift; multi-bit shifts clear it.
  always_comb begin
    one_of     = 1'b0;
    fin_status = status_q;
    case (op_q)
      OP_SHL, OP_SAL, OP_SHR, OP_SAR: begin
        if (op_q == OP_SHR) begin
          one_of = a_msb_q;
        end else if (op_q != OP_SAR) begin
          one_of = step_val[WIDTH-1] ^ step_cf;
        end
        fin_status = pack_flags(step_val, step_cf, single_q & one_of, status_q[4]);
      end
      OP_ROL, OP_RCL: begin
        one_of     = step_val[WIDTH-1] ^ step_cf;
        fin_status = {status_q[5:4], single_q & one_of, status_q[2:1], step_cf};
      end
      OP_ROR, OP_RCR: begin
        one_of     = step_val[WIDTH-1] ^ step_val[WIDTH-2];
        fin_status = {status_q[5:4], single_q & one_of, status_q[2:1], step_cf};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      work_q    <= '0;
      work_cf_q <= 1'b0;
      cnt_q     <= '0;
      single_q  <= 1'b0;
      a_msb_q   <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      op_q      <= bus.op;
      work_q    <= bus.a;
      work_cf_q <= status_q[0];
      cnt_q     <= cnt_in;
      single_q  <= (cnt_in == CW'(1));
      a_msb_q   <= bus.a[WIDTH-1];
      if (!go_exec) begin
        result_q <= imm_result;
        status_q <= imm_status;
        err_q    <= imm_err;
      end
    end else if (state == EXEC) begin
      work_q    <= step_val;
      work_cf_q <= step_cf;
      cnt_q     <= cnt_q - CW'(1);
      if (last_step) begin
        result_q <= step_val;
        status_q <= fin_status;
        err_q    <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_seq_n.md
# alu_seq_n

Parametrised, handshaked sequential ALU, successor to the 16-bit combinational ALU: same 5-bit opcode map, but WIDTH-generic, with a persistent status register whose CF feeds ADC/SBB/RCL/RCR, and multi-bit shifts/rotates executed iteratively one bit per cycle. It sits between an operand issue stage and a writeback stage, one operation in flight.

## Interface
- WIDTH, 16, operand/result width; legal range 8..64.
- CW, $clog2(WIDTH), derived; width of the shift-count field taken from b[CW-1:0].
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept (high only in IDLE).
- op  in  5  opcode.
- a  in  WIDTH  operand A / shift source.
- b  in  WIDTH  operand B; shift count = b[CW-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- status  out  6  registered flags {PF,AF,OF,SF,ZF,CF} = status[5:0].
- err  out  1  illegal opcode, valid with out_valid.

## Operation
- Opcodes: 00001 INC, 00011 DEC, 00100 ADD, 00101 ADC, 00110 SUB, 00111 SBB, 01000 AND, 01001 OR, 01010 XOR, 01011 NOT(a), 10000 SHL, 10001 SHR, 10010 SAL, 10011 SAR, 10100 ROL, 10101 ROR, 10110 RCL, 10111 RCR. All others illegal: result=0, err=1, status unchanged.
- FSM: IDLE -> (in_valid) EXEC if shift/rotate with count>0, else DONE. EXEC: one bit per cycle, count decrements, -> DONE when count reaches 0. DONE: out_valid=1, -> IDLE on out_ready.
- ADC/SBB carry-in = registered CF. RCL/RCR rotate through CF as a WIDTH+1-bit ring.
- Arithmetic flags: CF = carry out (borrow for SUB/SBB/DEC); OF = signed overflow; AF = carry/borrow across bit 3->4; SF = result[WIDTH-1]; ZF = result==0; PF = 1 when result[7:0] has even popcount. INC/DEC leave CF unchanged.
- Logic ops: CF=OF=AF=0; SF, ZF, PF from result.
- Shifts (SHL/SAL identical): CF = last bit shifted out; ZF, SF, PF from result; AF unchanged. Rotates update only CF and OF.
- OF for shift/rotate: count==1 only — SHL/SAL/ROL/RCL: result MSB xor CF; SHR: original a MSB; SAR: 0; ROR/RCR: result[WIDTH-1] xor result[WIDTH-2]. count>1: OF=0.
- Count 0: result=a, status unchanged, 1-cycle path.
- Status register updates only on entry to DONE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, status=0, err=0.
- Accept on rising edge with in_valid&&in_ready; op/a/b captured then, later input changes ignored.
- Non-shift ops and count 0: out_valid high the cycle after accept (latency 1).
- Shift/rotate count n>0: out_valid high n+1 cycles after accept.
- result/status/err stable while out_valid&&!out_ready; in_ready=0 throughout EXEC and DONE.
- Back-to-back: out_ready handshake returns to IDLE; next accept earliest the following edge (throughput 1 op / 2 cycles min).
- rst_n low at any time, including mid-EXEC: immediate return to reset values; partial operation discarded.

## Test plan
- WIDTH=16, after reset: ADD a=0x7FFF b=0x0001 -> 1 cycle later result=0x8000, OF=1, SF=1, AF=1, PF=1, CF=0, ZF=0.
- ADD 0xFFFF+0x0001 -> 0x0000, CF=1, ZF=1; then ADC 0x0000+0x0000 -> 0x0001, CF=0.
- SHL a=0x80F0 b=0x0003 -> out_valid 4 cycles after accept, result=0x0780, CF=0, OF=0, PF=0.
- SUB 0x0000-0x0001 (-> 0xFFFF, CF=1), then RCR a=0x8F00 b=3 -> result=0x31E0, CF=0, latency 4.
- Illegal op 00000 -> result=0, err=1, status equal to preceding value; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, a concurrent in_valid not accepted.
- ROL a=0x1234 b=15, rst_n low at cycle 5 of EXEC -> out_valid=0, result=0, status=0 immediately; in_ready=1 after release; fresh ROL b=4 on 0x1234 -> 0x2341.
